ldpc_snr_sweep_ctrl: RTL

LDPC_SNR_SWEEP_CTRL -- requirements
Module: ldpc_snr_sweep_ctrl

---
 rtl/ldpc_snr_sweep_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ldpc_snr_sweep_ctrl.sv
// SNR sweep controller: walks a table of {offset, factor} points, resets and runs the
// LDPC tester on each, waits for the pipeline to drain, then reports per-point statistics.
module ldpc_snr_sweep_ctrl #(
   parameter int unsigned NUM_POINTS = 16,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned DRAIN_HOLD = 8
) (
   input  logic        data_clk,
   input  logic        data_resetn,
   input  logic        cfg_start,
   input  logic        cfg_abort,
   input  logic [4:0]  cfg_num_points,
   input  logic        cfg_point_wr,
   input  logic [3:0]  cfg_point_addr,
   input  logic [23:0] cfg_point_data,
   input  logic [63:0] cfg_target_blocks,
   input  logic [63:0] cfg_target_failed,
   input  logic [63:0] stat_finished_blocks,
   input  logic [63:0] stat_failed_blocks,
   input  logic [63:0] stat_bit_errors,
   input  logic [31:0] stat_in_flight,
   output logic        ctrl_en,
   output logic        ctrl_sw_resetn,
   output logic [15:0] ctrl_factor,
   output logic [7:0]  ctrl_offset,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [3:0]  res_point,
   output logic [63:0] res_blocks,
   output logic [63:0] res_failed,
   output logic [63:0] res_bit_errors,
   output logic        busy,
   output logic        done,
   output logic        aborted
);

   typedef enum logic [2:0] {
      StIdle, StReset, StSettle, StRun, StDrain, StReport
   } state_e;

   state_e      state_q, state_d;
   logic [23:0] table_q [16];
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d, load_idx;
   logic [4:0]  num_q, num_d, num_clamped;
   logic        done_d, aborted_q, aborted_d;
   logic        load, snap, tbl_we, run_met, last_point;

   assign num_clamped = (cfg_num_points > 5'(NUM_POINTS)) ? 5'(NUM_POINTS) : cfg_num_points;
   assign tbl_we      = (state_q == StIdle) && cfg_point_wr &&
                        ({1'b0, cfg_point_addr} < 5'(NUM_POINTS));
   assign run_met     = (stat_finished_blocks >= cfg_target_blocks) ||
                        ((cfg_target_failed != 64'd0) && (stat_failed_blocks >= cfg_target_failed));
   assign last_point  = ({1'b0, idx_q} + 5'd1) >= num_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      num_d     = num_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      load      = 1'b0;
      load_idx  = idx_q;
      snap      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_start) begin
               aborted_d = 1'b0;
               if (cfg_num_points == 5'd0) begin
                  done_d = 1'b1;
               end else begin
                  num_d    = num_clamped;
                  idx_d    = 4'd0;
                  load     = 1'b1;
                  load_idx = 4'd0;
                  cnt_d    = 32'd0;
                  state_d  = StReset;
               end
            end
         end
         StReset, StSettle: begin
            if (cfg_abort) begin
               aborted_d = 1'b1;
               cnt_d     = 32'd0;
               state_d   = StDrain;
            end else if (state_q == StReset && cnt_q == RST_CYCLES - 1) begin
               cnt_d   = 32'd0;
               state_d = StSettle;
            end else if (state_q == StSettle && cnt_q == 32'd1) begin
               cnt_d   = 32'd0;
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StRun: begin
            if (cfg_abort || run_met) begin
               aborted_d = aborted_q | cfg_abort;
               cnt_d     = 32'd0;
               state_d   = StDrain;
            end
         end
         StDrain: begin
            // Only an unbroken run of empty cycles counts as drained.
            if (stat_in_flight != 32'd0) begin
               cnt_d = 32'd0;
            end else if (cnt_q == DRAIN_HOLD - 1) begin
               cnt_d = 32'd0;
               if (aborted_q) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  snap    = 1'b1;
                  state_d = StReport;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StReport: begin
            aborted_d = aborted_q | cfg_abort;
            if (res_ready) begin
               if (aborted_q || cfg_abort || last_point) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  idx_d    = idx_q + 4'd1;
                  load     = 1'b1;
                  load_idx = idx_q + 4'd1;
                  cnt_d    = 32'd0;
                  state_d  = StReset;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge data_clk or negedge data_resetn) begin
      if (!data_resetn) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         idx_q          <= '0;
         num_q          <= '0;
         done           <= 1'b0;
         aborted_q      <= 1'b0;
         ctrl_factor    <= '0;
         ctrl_offset    <= '0;
         res_point      <= '0;
         res_blocks     <= '0;
         res_failed     <= '0;
         res_bit_errors <= '0;
         for (int i = 0; i < 16; i++) table_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         num_q     <= num_d;
         done      <= done_d;
         aborted_q <= aborted_d;
         if (tbl_we) table_q[cfg_point_addr] <= cfg_point_data;
         if (load) begin
            ctrl_factor <= table_q[load_idx][15:0];
            ctrl_offset <= table_q[load_idx][23:16];
         end
         if (snap) begin
            res_point      <= idx_q;
            res_blocks     <= stat_finished_blocks;
            res_failed     <= stat_failed_blocks;
            res_bit_errors <= stat_bit_errors;
         end
      end
   end

   assign ctrl_en        = (state_q == StRun);
   assign ctrl_sw_resetn = (state_q != StReset);
   assign res_valid      = (state_q == StReport);
   assign busy           = (state_q != StIdle);
   assign aborted        = aborted_q;

endmodule
